rv32_data_bus_ctrl: RTL and testbench



---
 rtl/rv32_data_bus_ctrl_pkg.sv | 31 +++
 rtl/rv32_bus_decoder.sv | 37 +++
 rtl/rv32_data_bus_ctrl.sv | 120 ++++++++++++
 tb/tb_rv32_data_bus_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_data_bus_ctrl_pkg.sv
// Shared rv32 data-bus types: memory request bundle, bus FSM states.
// Targets are a one-hot vector: bit 0 = memory, bit i+1 = MMIO i, all-zero = NONE.
package rv32_data_bus_ctrl_pkg;

   typedef logic [31:0] rv32_word;

   typedef enum logic [1:0] {
      MEM_NOP   = 2'd0,
      MEM_READ  = 2'd1,
      MEM_WRITE = 2'd2
   } mem_op_t;

   typedef struct packed {
      mem_op_t  op;
      rv32_word addr;
      rv32_word wdata;
      logic [3:0] wstrb;
   } memory_request_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      ERR,
      DRAIN
   } bus_state_t;

   localparam int unsigned TGT_MEM = 0;

   localparam memory_request_t NOP_REQ = '{op: MEM_NOP, default: '0};

endpackage

// File: rtl/rv32_bus_decoder.sv
// Combinational address decode to a one-hot target (memory wins, then lowest MMIO).
// Ports: addr_i address; found_o any region hit; sel_o one-hot target (0 = NONE).
module rv32_bus_decoder
   import rv32_data_bus_ctrl_pkg::*;
#(
   parameter int unsigned                  NUM_MMIO       = 2,
   parameter logic [31:0]                  MEM_BASE       = 32'h0000_0000,
   parameter int unsigned                  MEM_SIZE_LOG2  = 16,
   parameter logic [NUM_MMIO-1:0][31:0]    MMIO_BASE      = {32'h8000_1000, 32'h8000_0000},
   parameter int unsigned                  MMIO_SIZE_LOG2 = 12
) (
   input  rv32_word          addr_i,
   output logic              found_o,
   output logic [NUM_MMIO:0] sel_o
);

   localparam logic [NUM_MMIO:0] ONE = (NUM_MMIO+1)'(1);

   logic [NUM_MMIO:0] match;
   logic              unused_addr;

   assign match[TGT_MEM] =
      addr_i[31:MEM_SIZE_LOG2] == MEM_BASE[31:MEM_SIZE_LOG2];

   for (genvar i = 0; i < NUM_MMIO; i++) begin : g_mmio
      assign match[i+1] =
         addr_i[31:MMIO_SIZE_LOG2] == MMIO_BASE[i][31:MMIO_SIZE_LOG2];
   end

   // Isolate the lowest set bit: memory is bit 0, so it has top priority.
   assign sel_o   = match & (~match + ONE);
   assign found_o = |match;

   // Offset bits inside a region do not take part in the decode.
   assign unused_addr = ^addr_i;

endmodule

// File: rtl/rv32_data_bus_ctrl.sv
// Data-bus controller: routes one core request at a time to memory or an MMIO target.
// Ports: core_* request/done/data/error; mem_* and mmio_* per-target request, done, data.
module rv32_data_bus_ctrl
   import rv32_data_bus_ctrl_pkg::*;
#(
   parameter int unsigned               NUM_MMIO       = 2,
   parameter logic [31:0]               MEM_BASE       = 32'h0000_0000,
   parameter int unsigned               MEM_SIZE_LOG2  = 16,
   parameter logic [NUM_MMIO-1:0][31:0] MMIO_BASE      = {32'h8000_1000, 32'h8000_0000},
   parameter int unsigned               MMIO_SIZE_LOG2 = 12,
   parameter int unsigned               TIMEOUT_CYCLES = 255
) (
   input  logic                              clk,
   input  logic                              reset,
   input  memory_request_t                   core_request,
   output logic                              core_request_done,
   output rv32_word                          core_data,
   output logic                              core_bus_error,
   output memory_request_t                   mem_request,
   input  logic                              mem_request_done,
   input  rv32_word                          mem_data,
   output memory_request_t [NUM_MMIO-1:0]    mmio_request,
   input  logic [NUM_MMIO-1:0]               mmio_request_done,
   input  logic [NUM_MMIO-1:0][31:0]         mmio_data
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] CNT_TMO = CW'(TIMEOUT_CYCLES);

   bus_state_t        state_q;
   memory_request_t   req_q;
   logic [NUM_MMIO:0] sel_q;
   logic [CW-1:0]     cnt_q;
   logic [CW-1:0]     cnt_d;

   logic              dec_found;
   logic [NUM_MMIO:0] dec_sel;
   logic              tgt_done;
   rv32_word          tgt_data;
   logic              timeout_hit;
   logic              busy;

   rv32_bus_decoder #(
      .NUM_MMIO       (NUM_MMIO),
      .MEM_BASE       (MEM_BASE),
      .MEM_SIZE_LOG2  (MEM_SIZE_LOG2),
      .MMIO_BASE      (MMIO_BASE),
      .MMIO_SIZE_LOG2 (MMIO_SIZE_LOG2)
   ) u_dec (
      .addr_i  (core_request.addr),
      .found_o (dec_found),
      .sel_o   (dec_sel)
   );

   // Done and data from the selected target only.
   always_comb begin
      tgt_done = sel_q[TGT_MEM] & mem_request_done;
      tgt_data = sel_q[TGT_MEM] ? mem_data : '0;
      for (int i = 0; i < NUM_MMIO; i++) begin
         tgt_done = tgt_done | (sel_q[i+1] & mmio_request_done[i]);
         if (sel_q[i+1]) tgt_data = tgt_data | mmio_data[i];
      end
   end

   assign cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_d == CNT_TMO);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         req_q   <= NOP_REQ;
         sel_q   <= '0;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (core_request.op != MEM_NOP) begin
                  req_q   <= core_request;
                  sel_q   <= dec_sel;
                  cnt_q   <= '0;
                  state_q <= dec_found ? BUSY : ERR;
               end
            end
            BUSY: begin
               // A done in the timeout cycle still completes normally.
               if (tgt_done) begin
                  state_q <= DRAIN;
               end else if (timeout_hit) begin
                  state_q <= ERR;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ERR: begin
               sel_q   <= '0;
               state_q <= DRAIN;
            end
            DRAIN: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Outputs are forced quiet during reset, whatever the old state.
   assign busy = (state_q == BUSY) && !reset;

   assign core_request_done =
      !reset && (((state_q == BUSY) && tgt_done) || (state_q == ERR));
   assign core_bus_error = !reset && (state_q == ERR);
   assign core_data = (!reset && (state_q == DRAIN)) ? tgt_data : '0;

   assign mem_request = (busy && sel_q[TGT_MEM]) ? req_q : NOP_REQ;

   for (genvar i = 0; i < NUM_MMIO; i++) begin : g_req
      assign mmio_request[i] = (busy && sel_q[i+1]) ? req_q : NOP_REQ;
   end

endmodule

// File: tb/tb_rv32_data_bus_ctrl.sv
// Randomized bench for rv32_data_bus_ctrl with a transaction-level timing model.
module tb_rv32_data_bus_ctrl;
   import rv32_data_bus_ctrl_pkg::*;

   localparam int NM  = 2;
   localparam int TMO = 8;
   localparam longint unsigned MEM_LO = 64'h0;
   localparam longint unsigned MEM_SZ = 64'h1_0000;
   localparam longint unsigned MB0    = 64'h8000_0000;
   localparam longint unsigned MB1    = 64'h8000_1000;
   localparam longint unsigned MM_SZ  = 64'h1000;

   logic clk = 1'b0;
   logic reset;
   memory_request_t core_request;
   logic core_request_done;
   logic [31:0] core_data;
   logic core_bus_error;
   memory_request_t mem_request;
   logic mem_request_done;
   logic [31:0] mem_data;
   memory_request_t [NM-1:0] mmio_request;
   logic [NM-1:0] mmio_request_done;
   logic [NM-1:0][31:0] mmio_data;

   always #5 clk = ~clk;

   rv32_data_bus_ctrl #(
      .NUM_MMIO       (NM),
      .MEM_BASE       (32'h0000_0000),
      .MEM_SIZE_LOG2  (16),
      .MMIO_BASE      ({32'h8000_1000, 32'h8000_0000}),
      .MMIO_SIZE_LOG2 (12),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .core_request      (core_request),
      .core_request_done (core_request_done),
      .core_data         (core_data),
      .core_bus_error    (core_bus_error),
      .mem_request       (mem_request),
      .mem_request_done  (mem_request_done),
      .mem_data          (mem_data),
      .mmio_request      (mmio_request),
      .mmio_request_done (mmio_request_done),
      .mmio_data         (mmio_data)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int acc_cyc = 0;
   bit chk_en = 0;

   bit exp_done, exp_err;
   logic [31:0] exp_data;
   int exp_fwd;
   memory_request_t exp_req;

   int obs_done_cyc;
   bit obs_err;
   logic [31:0] obs_data;

   bit fix_en = 0;
   logic [31:0] fix_val = 0;

   task automatic chk(input string nm, input logic [95:0] act,
                      input logic [95:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
      end
   endtask

   // Region membership by plain range arithmetic; 0=mem, i+1=MMIO i, -1=unmapped.
   function automatic int model_target(input logic [31:0] a);
      longint unsigned x = 64'(a);
      if (x >= MEM_LO && x < MEM_LO + MEM_SZ) return 0;
      if (x >= MB0 && x < MB0 + MM_SZ) return 1;
      if (x >= MB1 && x < MB1 + MM_SZ) return 2;
      return -1;
   endfunction

   function automatic logic [31:0] tgt_word(input int t);
      if (t == 0) return mem_data;
      return mmio_data[t-1];
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("done", 96'(core_request_done), 96'(exp_done));
         chk("bus_err", 96'(core_bus_error), 96'(exp_err));
         chk("core_data", 96'(core_data), 96'(exp_data));
         if (exp_fwd == 0) chk("mem_req", 96'(mem_request), 96'(exp_req));
         else chk("mem_op", 96'(mem_request.op), 96'(MEM_NOP));
         for (int i = 0; i < NM; i++) begin
            if (exp_fwd == i + 1)
               chk($sformatf("mmio%0d_req", i), 96'(mmio_request[i]), 96'(exp_req));
            else
               chk($sformatf("mmio%0d_op", i), 96'(mmio_request[i].op), 96'(MEM_NOP));
         end
         if (core_request_done) begin
            obs_done_cyc = cyc;
            obs_err = core_bus_error;
         end
         if (core_data != 0) obs_data = core_data;
      end
   end

   // Drive one cycle of inputs with random target noise; `quiet` target gets qval.
   task automatic set_inputs(input memory_request_t cr, input int quiet,
                             input bit qval);
      core_request = cr;
      mem_data = $urandom;
      mem_request_done = ($urandom_range(3) == 0);
      for (int i = 0; i < NM; i++) begin
         mmio_data[i] = $urandom;
         mmio_request_done[i] = ($urandom_range(3) == 0);
      end
      if (quiet == 0) mem_request_done = qval;
      else if (quiet > 0) mmio_request_done[quiet-1] = qval;
      exp_done = 0;
      exp_err = 0;
      exp_data = 0;
      exp_fwd = -1;
      exp_req = NOP_REQ;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // One transaction from acceptance to drain; the target answers after `lat`.
   task automatic do_txn(input memory_request_t r, input int lat,
                         input memory_request_t nxt);
      int t;
      int last;
      bit err;
      bit bz;
      t = model_target(r.addr);
      if (t < 0) begin
         last = 1;
         err = 1;
      end else if (lat <= TMO) begin
         last = lat;
         err = 0;
      end else begin
         last = TMO + 1;
         err = 1;
      end
      acc_cyc = cyc;
      set_inputs(r, -1, 0);
      tick();
      for (int j = 1; j <= last; j++) begin
         bz = !(err && j == last);
         set_inputs(r, bz ? t : -1, bz && (j == lat));
         if (bz) begin
            exp_fwd = t;
            exp_req = r;
         end
         exp_done = (j == last);
         exp_err = err && (j == last);
         tick();
      end
      set_inputs(nxt, -1, 0);
      if (fix_en && t == 0) mem_data = fix_val;
      exp_data = err ? 32'h0 : tgt_word(t);
      tick();
   endtask

   function automatic memory_request_t mk(input mem_op_t op, input logic [31:0] a);
      memory_request_t r;
      r.op = op;
      r.addr = a;
      r.wdata = $urandom;
      r.wstrb = 4'($urandom);
      return r;
   endfunction

   function automatic memory_request_t rnd_req();
      logic [31:0] bl [7] = '{32'h0000_FFFF, 32'h0001_0000, 32'h7FFF_FFFF,
                              32'h8000_0FFF, 32'h8000_1FFF, 32'h8000_2000,
                              32'hFFFF_FFFF};
      logic [31:0] a;
      mem_op_t op;
      op = ($urandom_range(1) == 1) ? MEM_WRITE : MEM_READ;
      case ($urandom_range(5))
         0, 1: a = {16'h0, 16'($urandom)};
         2: a = 32'h8000_0000 + $urandom_range(4095);
         3: a = 32'h8000_1000 + $urandom_range(4095);
         4: a = bl[$urandom_range(6)];
         default: a = $urandom;
      endcase
      return mk(op, a);
   endfunction

   function automatic int rnd_lat();
      int pick [4] = '{7, 8, 9, 12};
      if ($urandom_range(9) < 7) return int'($urandom_range(5, 1));
      return pick[$urandom_range(3)];
   endfunction

   localparam int NR = 60;
   memory_request_t reqs [NR];
   int lats [NR];
   bit b2b [NR];

   initial begin
      memory_request_t r, r2;
      reset = 1;
      core_request = NOP_REQ;
      mem_request_done = 0;
      mmio_request_done = '0;
      mem_data = 0;
      mmio_data = '0;
      exp_done = 0;
      exp_err = 0;
      exp_data = 0;
      exp_fwd = -1;
      exp_req = NOP_REQ;

      chk("dec_mem_0x40", 96'(model_target(32'h0000_0040)), 96'(0));
      chk("dec_mem_top", 96'(model_target(32'h0000_FFFF)), 96'(0));
      chk("dec_gap", 96'(model_target(32'h0001_0000)), 96'(-1));
      chk("dec_mmio0_top", 96'(model_target(32'h8000_0FFC)), 96'(1));
      chk("dec_mmio1", 96'(model_target(32'h8000_1004)), 96'(2));
      chk("dec_unmapped", 96'(model_target(32'h4000_0000)), 96'(-1));

      @(posedge clk);
      #1;
      chk_en = 1;
      for (int i = 0; i < 3; i++) begin
         set_inputs(mk(MEM_READ, 32'h40), -1, 0);
         tick();
      end
      reset = 0;
      set_inputs(NOP_REQ, -1, 0);
      tick();

      fix_en = 1;
      fix_val = 32'hDEAD_BEEF;
      do_txn(mk(MEM_READ, 32'h0000_0040), 3, NOP_REQ);
      fix_en = 0;
      chk("mem_done_lat", 96'(obs_done_cyc - acc_cyc), 96'(3));
      chk("mem_data_lit", 96'(obs_data), 96'(32'hDEAD_BEEF));
      chk("mem_no_err", 96'(obs_err), 96'(0));

      do_txn(mk(MEM_WRITE, 32'h8000_1004), 4, NOP_REQ);
      chk("mmio1_done_lat", 96'(obs_done_cyc - acc_cyc), 96'(4));
      chk("mmio1_no_err", 96'(obs_err), 96'(0));

      do_txn(mk(MEM_READ, 32'h4000_0000), 1, NOP_REQ);
      chk("unmap_done_lat", 96'(obs_done_cyc - acc_cyc), 96'(1));
      chk("unmap_err", 96'(obs_err), 96'(1));

      do_txn(mk(MEM_READ, 32'h8000_0010), 100, NOP_REQ);
      chk("tmo_done_lat", 96'(obs_done_cyc - acc_cyc), 96'(TMO + 1));
      chk("tmo_err", 96'(obs_err), 96'(1));
      while (cyc - acc_cyc <= 12) begin
         set_inputs(NOP_REQ, 1, (cyc - acc_cyc) == 12);
         tick();
      end

      r = mk(MEM_READ, 32'h0000_0100);
      set_inputs(r, -1, 0);
      tick();
      set_inputs(r, 0, 0);
      exp_fwd = 0;
      exp_req = r;
      tick();
      set_inputs(r, 0, 0);
      reset = 1;
      tick();
      reset = 0;
      set_inputs(NOP_REQ, 0, 0);
      tick();
      set_inputs(NOP_REQ, 0, 1);
      tick();
      do_txn(mk(MEM_READ, 32'h0000_0200), 2, NOP_REQ);

      r = mk(MEM_READ, 32'h0000_1000);
      r2 = mk(MEM_READ, 32'h8000_1008);
      do_txn(r, 2, r2);
      do_txn(r2, 3, NOP_REQ);

      for (int i = 0; i < NR; i++) begin
         reqs[i] = rnd_req();
         lats[i] = rnd_lat();
         b2b[i] = ($urandom_range(2) == 0);
      end
      for (int i = 0; i < NR; i++) begin
         if (i + 1 < NR && b2b[i+1]) begin
            do_txn(reqs[i], lats[i], reqs[i+1]);
         end else begin
            do_txn(reqs[i], lats[i], NOP_REQ);
            for (int k = 0; k < int'($urandom_range(2)); k++) begin
               set_inputs(NOP_REQ, -1, 0);
               tick();
            end
         end
      end

      set_inputs(NOP_REQ, -1, 0);
      tick();
      chk_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
